tiger_memory_stage: RTL and testbench
=====================================

TIGER_MEMORY_STAGE -- requirements
Module: tiger_memory_stage

Interface
REQ-001 The block SHALL use clock clk and reset reset, where reset is synchronous and active-high.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: reset  in  1  synchronous active-high reset.
REQ-004 Port: stall  in  1  global pipeline stall (includes this block's stallRq).
REQ-005 Port: clear  in  1  flush; squashes the current MA instruction.
REQ-006 Port: instrMA  in  32  instruction from execute.
REQ-007 Port: controlMA  in  CONTROL_WIDTH  control word from execute.
REQ-008 Port: executeoutMA  in  32  execute result (rt for MEML/MEMR).
REQ-009 Port: addrLowMA  in  2  bits [1:0] of the load/store address.
REQ-010 Port: memReadData  in  32  data-memory read data, little-endian lanes.
REQ-011 Port: memReadValid  in  1  memReadData valid this cycle.
REQ-012 Port: instrWB, controlWB, writedataWB  out  32/CONTROL_WIDTH/32  registered writeback outputs.
REQ-013 Port: stallRq  out  1  combinational stall request.

Function
REQ-014 FSM states: IDLE, WAIT, HELD; the FSM SHALL leave IDLE only when controlMA[CONTROL_MEMREAD]=1 and clear=0.
REQ-015 IDLE, load, memReadValid=1: stall=0 -> IDLE with WB registers loaded; stall=1 -> HELD with aligned data captured into hold register.
REQ-016 IDLE, load, memReadValid=0: -> WAIT.
REQ-017 WAIT: memReadValid=0 -> remain WAIT; memReadValid=1 and stall=0 -> IDLE with WB loaded; memReadValid=1 and stall=1 -> HELD with data captured.
REQ-018 HELD: stall=1 -> remain HELD, ignore memReadValid; stall=0 -> IDLE with WB loaded from hold register.
REQ-019 stallRq SHALL be 1 iff MEMREAD=1, clear=0, state!=HELD and memReadValid=0.
REQ-020 Load alignment, MEM8: byte = memReadData[8*addrLowMA +: 8]; MEM16: half = addrLowMA[1] ? [31:16] : [15:0]; otherwise full word.
REQ-021 Zero-extend byte/half when controlMA[CONTROL_ALUCONTROL_UNSIGNED]=1; otherwise sign-extend to 32 bits.
REQ-022 When stall=0, the block SHALL register instrWB<=instrMA, controlWB<=controlMA, and writedataWB<=aligned load data (load) or executeoutMA (non-load); when stall=1, all WB outputs SHALL hold.
REQ-023 Stores SHALL pass through without waiting on memReadValid; stallRq SHALL stay 0 for stores.
REQ-024 clear=1 (reset=0) SHALL zero all WB outputs, return the FSM to IDLE, and force stallRq=0, overriding stall.
REQ-025 A memReadValid arriving in IDLE with no load SHALL be ignored.

Reset
REQ-026 On reset: instrWB=0, controlWB=0, writedataWB=0, hold register=0, FSM=IDLE, stallRq=0 from the following cycle.
REQ-027 Reset mid-WAIT or mid-HELD SHALL abandon the load; any later memReadValid is ignored per REQ-025.

Configuration
REQ-028 Macro TIGER_UNALIGNED_EN defined: MEML (LWL) and MEMR (LWR) loads SHALL merge memory bytes into executeoutMA (rt) by addrLowMA per MIPS little-endian semantics, with the same FSM and latency as other loads.
REQ-029 Macro TIGER_UNALIGNED_EN undefined: MEML/MEMR SHALL be treated as full-word loads and the merge logic SHALL be absent.

Structure
REQ-030 FSM state encoding and the CONTROL_* field defines SHALL reside in tiger_defines.v.
REQ-031 Alignment, extension and merge SHALL be one combinational sub-module, tiger_load_align; the FSM, hold register and WB registers SHALL reside in tiger_memory_stage.

Verification
REQ-032 LW with addrLow=0, data 0x8765_4321 valid the same cycle, stall=0 -> writedataWB=0x8765_4321 next cycle, stallRq never asserted.
REQ-033 LB signed with addrLow=2, data 0x0080_0000 valid after 3 cycles -> stallRq=1 for 3 cycles, then writedataWB=0xFFFF_FF80; LBU on the same data -> 0x0000_0080.
REQ-034 LH with addrLow=2, data 0x1234_5678 valid while stall=1 from another stage for 2 cycles -> HELD, stallRq=0, WB held; on release writedataWB=0x0000_1234.
REQ-035 clear asserted in WAIT, then data valid -> WB outputs 0, FSM IDLE, late data ignored.
REQ-036 TIGER_UNALIGNED_EN: LWL with addrLow=1, rt=0xAABB_CCDD, mem=0x1122_3344 -> writedataWB=0x3344_CCDD; without the macro -> 0x1122_3344.
REQ-037 Back-to-back ADD result 0x5 then SW -> writedataWB=0x5 then the SW executeout, stallRq=0 throughout.

Source files
------------

// File: rtl/tiger_memory_stage_pkg.sv
// tiger_memory_stage_pkg: shared definitions for the memory stage.
// Holds the control-word field positions (CONTROL_*), the load-size
// encodings and the memory-stage FSM state encoding.
package tiger_memory_stage_pkg;

    localparam int CONTROL_WIDTH               = 16;
    localparam int CONTROL_MEMREAD             = 0;
    localparam int CONTROL_MEMWRITE            = 1;
    localparam int CONTROL_MEMSIZE_LO          = 2;
    localparam int CONTROL_MEMSIZE_W           = 3;
    localparam int CONTROL_ALUCONTROL_UNSIGNED = 5;

    // Load/store size codes carried in the CONTROL_MEMSIZE field.
    typedef enum logic [2:0] {
        MEM32 = 3'd0,
        MEM16 = 3'd1,
        MEM8  = 3'd2,
        MEML  = 3'd3,
        MEMR  = 3'd4
    } mem_size_t;

    // Memory-stage FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HELD = 2'd2
    } mem_state_t;

    // Extract the size field from a control word.
    function automatic logic [2:0] get_mem_size(input logic [CONTROL_WIDTH-1:0] ctrl);
        return ctrl[CONTROL_MEMSIZE_LO +: CONTROL_MEMSIZE_W];
    endfunction

endpackage

// File: rtl/tiger_load_align.sv
// tiger_load_align: combinational load-data alignment.
// Picks the addressed byte/half from the little-endian read word and
// sign- or zero-extends it. With TIGER_UNALIGNED_EN defined, LWL/LWR merge
// memory bytes into rt; otherwise they fall through as full-word loads.
module tiger_load_align
    import tiger_memory_stage_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_rt,
    input  logic [1:0]  i_addr_low,
    input  logic [31:0] i_mem_data,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_mem_data[{i_addr_low, 3'b000} +: 8];
    assign w_half = i_addr_low[1] ? i_mem_data[31:16] : i_mem_data[15:0];

`ifdef TIGER_UNALIGNED_EN
    logic [31:0] w_lwl;
    logic [31:0] w_lwr;

    // Merge memory bytes into rt: LWL fills the top bytes, LWR the bottom bytes.
    always_comb begin
        w_lwl = i_rt;
        w_lwr = i_rt;
        for (int i = 0; i < 4; i++) begin
            if (i >= 3 - int'(i_addr_low)) begin
                w_lwl[8*i +: 8] = i_mem_data[8*(i - 3 + int'(i_addr_low)) +: 8];
            end else begin
                w_lwl[8*i +: 8] = i_rt[8*i +: 8];
            end
            if (i <= 3 - int'(i_addr_low)) begin
                w_lwr[8*i +: 8] = i_mem_data[8*(i + int'(i_addr_low)) +: 8];
            end else begin
                w_lwr[8*i +: 8] = i_rt[8*i +: 8];
            end
        end
    end
`else
    logic w_unused_rt;
    assign w_unused_rt = ^i_rt;
`endif

    // Select the final 32-bit load value according to the access size.
    always_comb begin
        o_data = i_mem_data;
        case (i_size)
            MEM8: begin
                if (i_unsigned) begin
                    o_data = {24'd0, w_byte};
                end else begin
                    o_data = {{24{w_byte[7]}}, w_byte};
                end
            end
            MEM16: begin
                if (i_unsigned) begin
                    o_data = {16'd0, w_half};
                end else begin
                    o_data = {{16{w_half[15]}}, w_half};
                end
            end
`ifdef TIGER_UNALIGNED_EN
            MEML:    o_data = w_lwl;
            MEMR:    o_data = w_lwr;
`endif
            default: o_data = i_mem_data;
        endcase
    end

endmodule

// File: rtl/tiger_memory_stage.sv
// tiger_memory_stage: MA -> WB pipeline stage with a load-wait FSM.
// Loads wait for memReadValid (requesting a stall meanwhile); data that
// arrives while the pipeline is stalled elsewhere is parked in a hold
// register until the stall releases. Optional build macro:
// TIGER_UNALIGNED_EN enables LWL/LWR merging inside tiger_load_align.
module tiger_memory_stage
    import tiger_memory_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     clear,
    input  logic [31:0]              instrMA,
    input  logic [CONTROL_WIDTH-1:0] controlMA,
    input  logic [31:0]              executeoutMA,
    input  logic [1:0]               addrLowMA,
    input  logic [31:0]              memReadData,
    input  logic                     memReadValid,
    output logic [31:0]              instrWB,
    output logic [CONTROL_WIDTH-1:0] controlWB,
    output logic [31:0]              writedataWB,
    output logic                     stallRq
);

    mem_state_t               r_state;
    mem_state_t               w_state_next;
    logic                     w_load;
    logic                     w_capture;
    logic                     w_stall_rq;
    logic [2:0]               w_size;
    logic [31:0]              w_aligned;
    logic [31:0]              w_wb_data;
    logic [31:0]              r_hold;
    logic [31:0]              r_instr_wb;
    logic [CONTROL_WIDTH-1:0] r_control_wb;
    logic [31:0]              r_data_wb;

    // A flushed instruction is never treated as a live load.
    assign w_load = controlMA[CONTROL_MEMREAD] & ~clear;
    assign w_size = get_mem_size(controlMA);

    tiger_load_align u_align (
        .i_size     (w_size),
        .i_unsigned (controlMA[CONTROL_ALUCONTROL_UNSIGNED]),
        .i_rt       (executeoutMA),
        .i_addr_low (addrLowMA),
        .i_mem_data (memReadData),
        .o_data     (w_aligned)
    );

    // Request a stall while a live load is still waiting for its data.
    always_comb begin
        w_stall_rq = 1'b0;
        if (w_load && (r_state != HELD) && !memReadValid) begin
            w_stall_rq = 1'b1;
        end else begin
            w_stall_rq = 1'b0;
        end
    end

    assign stallRq = w_stall_rq;

    // Next-state logic; data arriving under an external stall is captured.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_load && memReadValid) begin
                    if (stall) begin
                        w_state_next = HELD;
                        w_capture    = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else if (w_load) begin
                    w_state_next = WAIT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            WAIT: begin
                if (memReadValid) begin
                    if (stall) begin
                        w_state_next = HELD;
                        w_capture    = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_state_next = WAIT;
                end
            end
            HELD: begin
                if (stall) begin
                    w_state_next = HELD;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (clear) begin
            w_state_next = IDLE;
            w_capture    = 1'b0;
        end else begin
            w_capture    = w_capture;
        end
    end

    // Writeback data source: parked data, fresh load data, or execute result.
    always_comb begin
        w_wb_data = executeoutMA;
        if (r_state == HELD) begin
            w_wb_data = r_hold;
        end else if (controlMA[CONTROL_MEMREAD]) begin
            w_wb_data = w_aligned;
        end else begin
            w_wb_data = executeoutMA;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Hold register: parks load data that completed while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold <= 32'd0;
        end else if (clear) begin
            r_hold <= 32'd0;
        end else if (w_capture) begin
            r_hold <= w_aligned;
        end else begin
            r_hold <= r_hold;
        end
    end

    // Writeback registers: flush zeroes them, stall freezes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_wb   <= 32'd0;
            r_control_wb <= '0;
            r_data_wb    <= 32'd0;
        end else if (clear) begin
            r_instr_wb   <= 32'd0;
            r_control_wb <= '0;
            r_data_wb    <= 32'd0;
        end else if (!stall) begin
            r_instr_wb   <= instrMA;
            r_control_wb <= controlMA;
            r_data_wb    <= w_wb_data;
        end else begin
            r_instr_wb   <= r_instr_wb;
            r_control_wb <= r_control_wb;
            r_data_wb    <= r_data_wb;
        end
    end

    assign instrWB     = r_instr_wb;
    assign controlWB   = r_control_wb;
    assign writedataWB = r_data_wb;

endmodule

// File: tb/tb_tiger_memory_stage.sv
// tb_tiger_memory_stage: directed scenarios plus randomized transactions
// checked against a transaction-level reference model.
module tb_tiger_memory_stage;
    import tiger_memory_stage_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     clear;
    logic                     ext_stall;
    logic                     stall;
    logic [31:0]              instrMA;
    logic [CONTROL_WIDTH-1:0] controlMA;
    logic [31:0]              executeoutMA;
    logic [1:0]               addrLowMA;
    logic [31:0]              memReadData;
    logic                     memReadValid;
    logic [31:0]              instrWB;
    logic [CONTROL_WIDTH-1:0] controlWB;
    logic [31:0]              writedataWB;
    logic                     stallRq;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] wb_data_exp;

    // The global stall is this stage's request OR'd with other stages' stalls.
    assign stall = ext_stall | stallRq;

    always #5 clk = ~clk;

    tiger_memory_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .clear        (clear),
        .instrMA      (instrMA),
        .controlMA    (controlMA),
        .executeoutMA (executeoutMA),
        .addrLowMA    (addrLowMA),
        .memReadData  (memReadData),
        .memReadValid (memReadValid),
        .instrWB      (instrWB),
        .controlWB    (controlWB),
        .writedataWB  (writedataWB),
        .stallRq      (stallRq)
    );

    function automatic logic [CONTROL_WIDTH-1:0] mk_ctrl(input bit rd, input bit wr,
            input logic [2:0] sz, input bit uns, input logic [CONTROL_WIDTH-1:0] noise);
        logic [CONTROL_WIDTH-1:0] c;
        c = noise;
        c[CONTROL_MEMREAD] = rd;
        c[CONTROL_MEMWRITE] = wr;
        c[CONTROL_MEMSIZE_LO +: CONTROL_MEMSIZE_W] = sz;
        c[CONTROL_ALUCONTROL_UNSIGNED] = uns;
        return c;
    endfunction

    // Reference load result computed arithmetically from the load rules.
    function automatic logic [31:0] ref_load(input logic [CONTROL_WIDTH-1:0] c,
            input logic [31:0] rt, input logic [1:0] a, input logic [31:0] m);
        logic [63:0] acc;
        logic [31:0] v;
        logic [2:0]  sz;
        bit          uns;
        int          sh;
        sz  = c[CONTROL_MEMSIZE_LO +: CONTROL_MEMSIZE_W];
        uns = c[CONTROL_ALUCONTROL_UNSIGNED];
        v   = m;
        acc = 64'd0;
        sh  = 0;
        if (sz == MEM8) begin
            v = (m >> (8 * a)) & 32'h0000_00FF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (sz == MEM16) begin
            v = (a >= 2'd2) ? (m >> 16) : (m & 32'h0000_FFFF);
            if (!uns && v >= 32'h0000_8000) v = v - 32'h0001_0000;
        end
`ifdef TIGER_UNALIGNED_EN
        else if (sz == MEML) begin
            sh  = 8 * (3 - int'(a));
            acc = ({32'd0, m} << sh) | ({32'd0, rt} & ((64'd1 << sh) - 64'd1));
            v   = acc[31:0];
        end else if (sz == MEMR) begin
            sh  = 8 * int'(a);
            acc = ({32'd0, m} >> sh) | ({32'd0, rt} & ~(64'h0000_0000_FFFF_FFFF >> sh));
            v   = acc[31:0];
        end
`endif
        return v;
    endfunction

    task automatic idle_inputs();
        @(negedge clk);
        clear        = 1'b0;
        ext_stall    = 1'b0;
        controlMA    = '0;
        memReadValid = 1'b0;
    endtask

    // Present one instruction until the stage accepts it; report observations.
    task automatic drive_txn(input logic [31:0] instr, input logic [CONTROL_WIDTH-1:0] ctrl,
            input logic [31:0] rt, input logic [1:0] a, input logic [31:0] mem,
            input int lat, input int es_start, input int es_len, input logic [31:0] prev_data,
            output int cycles, output int rq_cycles, output bit held_ok, output bit timed_out);
        bit done;
        done = 1'b0; cycles = 0; rq_cycles = 0; held_ok = 1'b1; timed_out = 1'b0;
        while (!done) begin
            @(negedge clk);
            instrMA      = instr;
            controlMA    = ctrl;
            executeoutMA = rt;
            addrLowMA    = a;
            memReadValid = (cycles == lat);
            memReadData  = memReadValid ? mem : $urandom;
            ext_stall    = (cycles >= es_start) && (cycles < es_start + es_len);
            #1;
            if (stallRq === 1'b1) rq_cycles++;
            done = (stall === 1'b0);
            @(posedge clk);
            #1;
            if (!done && writedataWB !== prev_data) held_ok = 1'b0;
            cycles++;
            if (!done && cycles >= 20) begin
                timed_out = 1'b1;
                done = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; ext_stall = 1'b0; memReadValid = 1'b0;
        controlMA = '0; instrMA = $urandom; executeoutMA = $urandom;
        addrLowMA = 2'd0; memReadData = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (instrWB !== 32'd0) begin n_err++; $display("FAIL reset_instr: got %h expected 0", instrWB); end
        n_cmp++; if (controlWB !== '0) begin n_err++; $display("FAIL reset_ctrl: got %h expected 0", controlWB); end
        n_cmp++; if (writedataWB !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h expected 0", writedataWB); end
        n_cmp++; if (stallRq !== 1'b0) begin n_err++; $display("FAIL reset_stallrq: got %b expected 0", stallRq); end
        // Enter WAIT, then reset mid-wait; the late data must be ignored.
        @(negedge clk);
        controlMA = mk_ctrl(1'b1, 1'b0, MEM32, 1'b0, '0);
        #1;
        n_cmp++; if (stallRq !== 1'b1) begin n_err++; $display("FAIL wait_stallrq: got %b expected 1", stallRq); end
        @(negedge clk);
        reset = 1'b1; controlMA = '0;
        @(negedge clk);
        reset = 1'b0; instrMA = 32'h0000_00AB; executeoutMA = 32'h1111_2222;
        memReadValid = 1'b1; memReadData = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (stallRq !== 1'b0) begin n_err++; $display("FAIL late_valid_stallrq: got %b expected 0", stallRq); end
        @(posedge clk);
        #1;
        n_cmp++; if (writedataWB !== 32'h1111_2222) begin n_err++; $display("FAIL late_valid_data: got %h expected 11112222", writedataWB); end
        wb_data_exp = 32'h1111_2222;
        idle_inputs();
    endtask

    task automatic test_lw();
        int cyc, rq; bit hok, to;
        logic [CONTROL_WIDTH-1:0] c;
        c = mk_ctrl(1'b1, 1'b0, MEM32, 1'b0, 16'h0300);
        drive_txn(32'h8C01_0000, c, 32'h0, 2'd0, 32'h8765_4321, 0, 0, 0, wb_data_exp, cyc, rq, hok, to);
        n_cmp++; if (to || cyc != 1) begin n_err++; $display("FAIL lw_cycles: got %0d expected 1", cyc); end
        n_cmp++; if (rq != 0) begin n_err++; $display("FAIL lw_stallrq: got %0d cycles expected 0", rq); end
        n_cmp++; if (writedataWB !== 32'h8765_4321) begin n_err++; $display("FAIL lw_data: got %h expected 87654321", writedataWB); end
        n_cmp++; if (instrWB !== 32'h8C01_0000 || controlWB !== c) begin n_err++; $display("FAIL lw_instr_ctrl: got %h/%h expected 8c010000/%h", instrWB, controlWB, c); end
        wb_data_exp = 32'h8765_4321;
    endtask

    task automatic test_lb_wait();
        int cyc, rq; bit hok, to;
        drive_txn(32'h8001_0002, mk_ctrl(1'b1, 1'b0, MEM8, 1'b0, '0), 32'h0, 2'd2, 32'h0080_0000,
                  3, 0, 0, wb_data_exp, cyc, rq, hok, to);
        n_cmp++; if (to || rq != 3) begin n_err++; $display("FAIL lb_stallrq: got %0d cycles expected 3", rq); end
        n_cmp++; if (!hok) begin n_err++; $display("FAIL lb_wb_hold: got changed expected %h", wb_data_exp); end
        n_cmp++; if (writedataWB !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_data: got %h expected ffffff80", writedataWB); end
        wb_data_exp = 32'hFFFF_FF80;
        drive_txn(32'h9001_0002, mk_ctrl(1'b1, 1'b0, MEM8, 1'b1, '0), 32'h0, 2'd2, 32'h0080_0000,
                  3, 0, 0, wb_data_exp, cyc, rq, hok, to);
        n_cmp++; if (to || rq != 3) begin n_err++; $display("FAIL lbu_stallrq: got %0d cycles expected 3", rq); end
        n_cmp++; if (writedataWB !== 32'h0000_0080) begin n_err++; $display("FAIL lbu_data: got %h expected 00000080", writedataWB); end
        wb_data_exp = 32'h0000_0080;
    endtask

    task automatic test_lh_held();
        int cyc, rq; bit hok, to;
        drive_txn(32'h8401_0002, mk_ctrl(1'b1, 1'b0, MEM16, 1'b0, '0), 32'h0, 2'd2, 32'h1234_5678,
                  0, 0, 2, wb_data_exp, cyc, rq, hok, to);
        n_cmp++; if (to || cyc != 3) begin n_err++; $display("FAIL lh_cycles: got %0d expected 3", cyc); end
        n_cmp++; if (rq != 0) begin n_err++; $display("FAIL lh_stallrq: got %0d cycles expected 0", rq); end
        n_cmp++; if (!hok) begin n_err++; $display("FAIL lh_wb_hold: got changed expected %h", wb_data_exp); end
        n_cmp++; if (writedataWB !== 32'h0000_1234) begin n_err++; $display("FAIL lh_data: got %h expected 00001234", writedataWB); end
        wb_data_exp = 32'h0000_1234;
    endtask

    task automatic test_clear();
        @(negedge clk);
        instrMA = 32'h8C02_0000; controlMA = mk_ctrl(1'b1, 1'b0, MEM32, 1'b0, '0);
        executeoutMA = 32'h0; memReadValid = 1'b0; ext_stall = 1'b0;
        #1;
        n_cmp++; if (stallRq !== 1'b1) begin n_err++; $display("FAIL clr_wait_stallrq: got %b expected 1", stallRq); end
        @(negedge clk);
        clear = 1'b1; ext_stall = 1'b1;
        #1;
        n_cmp++; if (stallRq !== 1'b0) begin n_err++; $display("FAIL clr_stallrq: got %b expected 0", stallRq); end
        @(posedge clk);
        #1;
        n_cmp++; if (instrWB !== 32'd0 || controlWB !== '0 || writedataWB !== 32'd0) begin
            n_err++; $display("FAIL clr_wb_zero: got %h/%h/%h expected 0/0/0", instrWB, controlWB, writedataWB); end
        @(negedge clk);
        clear = 1'b0; ext_stall = 1'b0; controlMA = '0; instrMA = 32'd0; executeoutMA = 32'd0;
        memReadValid = 1'b1; memReadData = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (stallRq !== 1'b0) begin n_err++; $display("FAIL clr_late_stallrq: got %b expected 0", stallRq); end
        @(posedge clk);
        #1;
        n_cmp++; if (writedataWB !== 32'd0) begin n_err++; $display("FAIL clr_late_data: got %h expected 0", writedataWB); end
        wb_data_exp = 32'd0;
        idle_inputs();
    endtask

    task automatic test_unaligned();
        int cyc, rq; bit hok, to;
        logic [31:0] exp_l, exp_r;
`ifdef TIGER_UNALIGNED_EN
        exp_l = 32'h3344_CCDD;
        exp_r = 32'hAA11_2233;
`else
        exp_l = 32'h1122_3344;
        exp_r = 32'h1122_3344;
`endif
        drive_txn(32'h8801_0001, mk_ctrl(1'b1, 1'b0, MEML, 1'b0, '0), 32'hAABB_CCDD, 2'd1, 32'h1122_3344,
                  1, 0, 0, wb_data_exp, cyc, rq, hok, to);
        n_cmp++; if (to || writedataWB !== exp_l) begin n_err++; $display("FAIL lwl_data: got %h expected %h", writedataWB, exp_l); end
        wb_data_exp = exp_l;
        drive_txn(32'h9801_0001, mk_ctrl(1'b1, 1'b0, MEMR, 1'b0, '0), 32'hAABB_CCDD, 2'd1, 32'h1122_3344,
                  1, 0, 0, wb_data_exp, cyc, rq, hok, to);
        n_cmp++; if (to || writedataWB !== exp_r) begin n_err++; $display("FAIL lwr_data: got %h expected %h", writedataWB, exp_r); end
        wb_data_exp = exp_r;
    endtask

    task automatic test_back_to_back();
        int cyc, rq; bit hok, to;
        drive_txn(32'h0022_0820, mk_ctrl(1'b0, 1'b0, MEM32, 1'b0, '0), 32'h0000_0005, 2'd0, 32'h0,
                  -1, 0, 0, wb_data_exp, cyc, rq, hok, to);
        n_cmp++; if (to || cyc != 1 || rq != 0 || writedataWB !== 32'h5) begin
            n_err++; $display("FAIL b2b_add: got data %h rq %0d expected 00000005 rq 0", writedataWB, rq); end
        wb_data_exp = 32'h5;
        drive_txn(32'hAC01_0000, mk_ctrl(1'b0, 1'b1, MEM32, 1'b0, '0), 32'hCAFE_F00D, 2'd0, 32'h1357_9BDF,
                  0, 0, 0, wb_data_exp, cyc, rq, hok, to);
        n_cmp++; if (to || cyc != 1 || rq != 0 || writedataWB !== 32'hCAFE_F00D) begin
            n_err++; $display("FAIL b2b_sw: got data %h rq %0d expected cafef00d rq 0", writedataWB, rq); end
        wb_data_exp = 32'hCAFE_F00D;
    endtask

    task automatic test_random();
        logic [31:0] r32, instr, rt, mem, exp_instr, exp_data;
        logic [CONTROL_WIDTH-1:0] ctrl, exp_ctrl;
        logic [1:0] a;
        int kind, lat, es_start, es_len, c;
        bit stray, got, accepted, exp_rq, stall_now;
        exp_instr = instrWB === instrWB ? 32'h0 : 32'h0;
        exp_instr = 32'h0000_0000; exp_ctrl = '0; exp_data = wb_data_exp;
        // Seed the model with a known ALU result first.
        @(negedge clk);
        instrMA = 32'h0000_1234; controlMA = '0; executeoutMA = 32'h0BAD_F00D;
        memReadValid = 1'b0; ext_stall = 1'b0;
        @(posedge clk);
        exp_instr = 32'h0000_1234; exp_ctrl = '0; exp_data = 32'h0BAD_F00D;
        for (int t = 0; t < 60; t++) begin
            kind = int'($urandom_range(0, 2));
            r32 = $urandom;
            ctrl = mk_ctrl(kind == 2, kind == 1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), r32[CONTROL_WIDTH-1:0]);
            instr = $urandom; rt = $urandom; mem = $urandom; a = 2'($urandom_range(0, 3));
            lat = int'($urandom_range(0, 3));
            es_start = int'($urandom_range(0, 3));
            es_len = int'($urandom_range(0, 2));
            stray = (kind != 2) && ($urandom_range(0, 1) == 1);
            got = 1'b0; accepted = 1'b0; c = 0;
            while (!accepted && c < 20) begin
                @(negedge clk);
                instrMA = instr; controlMA = ctrl; executeoutMA = rt; addrLowMA = a;
                memReadValid = (kind == 2 || stray) && (c == lat);
                memReadData = memReadValid ? mem : $urandom;
                ext_stall = (c >= es_start) && (c < es_start + es_len);
                #1;
                exp_rq = (kind == 2) && !got && !memReadValid;
                n_cmp++; if (stallRq !== exp_rq) begin n_err++; $display("FAIL rnd_stallrq t%0d c%0d: got %b expected %b", t, c, stallRq, exp_rq); end
                stall_now = ext_stall || exp_rq;
                if (kind == 2 && memReadValid) got = 1'b1;
                @(posedge clk);
                #1;
                if (!stall_now) begin
                    exp_instr = instr; exp_ctrl = ctrl;
                    exp_data = (kind == 2) ? ref_load(ctrl, rt, a, mem) : rt;
                    accepted = 1'b1;
                end
                n_cmp++;
                if (instrWB !== exp_instr || controlWB !== exp_ctrl || writedataWB !== exp_data) begin
                    n_err++; $display("FAIL rnd_wb t%0d c%0d: got %h/%h/%h expected %h/%h/%h", t, c,
                                      instrWB, controlWB, writedataWB, exp_instr, exp_ctrl, exp_data);
                end
                c++;
            end
            n_cmp++; if (!accepted) begin n_err++; $display("FAIL rnd_timeout t%0d: got no acceptance expected one within 20 cycles", t); end
        end
        wb_data_exp = exp_data;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_wait();
        test_lh_held();
        test_clear();
        test_unaligned();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
